// File: rtl/digitizer_pkg.sv
// Shared types for the digitizer capture path: trigger modes, capture FSM
// states and the sample-word to byte-count conversion.
package digitizer_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    EXT   = 2'd1,
    LEVEL = 2'd2
  } capture_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } capture_state_e;

  // floor(log2(beat_bytes)); packet_bytes is shifted right by this to get beats
  function automatic int beat_shift(input int beat_bytes);
    int s;
    s = 0;
    for (int i = 1; i < 8; i++) begin
      if ((1 << i) <= beat_bytes) s = i;
    end
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head.
// Capacity is exactly DEPTH; a write while full is accepted if a read happens too.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_rd      = rd_en && !empty;
  assign do_wr      = wr_en && (!full || do_rd);
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr_nxt;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Head register tracks mem[rd_ptr]; bypass the write when the head slot is new.
      if (do_rd) begin
        if (count > (AW+1)'(1))
          rd_data <= mem[rd_ptr_nxt];
        else if (do_wr)
          rd_data <= wr_data;
      end else if (empty && do_wr) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Trigger-qualified capture of packed ADC sample words into fixed-length
// AXI-Stream packets, buffered through a FWFT FIFO with overflow accounting.
module adc_capture_ctrl
  import digitizer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic                     s_valid,
  input  logic                     trig_in,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic                     continuous,
  input  logic [31:0]              packet_bytes,
  input  logic [DATA_W-1:0]        threshold,
  output logic [NUM_CH*DATA_W-1:0] m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic                     cfg_error
);

  localparam int BEAT_W = NUM_CH * DATA_W;
  localparam int SHIFT  = beat_shift(BEAT_W / 8);

  capture_state_e           state;
  capture_mode_e            mode_q, mode_new;
  logic                     cont_q;
  logic [31:0]              n_q, n_new, beat_cnt;
  logic signed [DATA_W-1:0] thr_q, prev_ch0, ch0;
  logic                     trig_prev, trig_seen, trig_edge, trig_hit;
  logic                     stop_pending;

  logic                     fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [BEAT_W:0]          fifo_din, fifo_dout;
  logic                     space, is_last, final_hs;

  assign ch0       = s_data[DATA_W-1:0];
  assign n_new     = packet_bytes >> SHIFT;
  assign trig_edge = trig_in && !trig_prev;

  always_comb begin
    mode_new = FREE;
    case (mode)
      2'd1:    mode_new = EXT;
      2'd2:    mode_new = LEVEL;
      default: mode_new = FREE;
    endcase
  end

  always_comb begin
    trig_hit = 1'b0;
    case (mode_q)
      EXT:     trig_hit = s_valid && (trig_edge || trig_seen);
      LEVEL:   trig_hit = s_valid && (prev_ch0 < thr_q) && (thr_q <= ch0);
      default: trig_hit = 1'b0;
    endcase
  end

  // Full is judged before the read, so a simultaneous pop makes room.
  assign fifo_rd  = m_tready && !fifo_empty;
  assign space    = !fifo_full || fifo_rd;
  assign is_last  = (beat_cnt == n_q - 32'd1);
  assign fifo_wr  = s_valid && space &&
                    ((state == CAPTURE) || (state == ARMED && trig_hit && !stop));
  assign fifo_din = {is_last, s_data};
  assign final_hs = (state == DRAIN) && m_tvalid && m_tready && m_tlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      mode_q       <= FREE;
      cont_q       <= 1'b0;
      n_q          <= '0;
      thr_q        <= '0;
      beat_cnt     <= '0;
      prev_ch0     <= {1'b1, {(DATA_W-1){1'b0}}};
      trig_prev    <= 1'b0;
      trig_seen    <= 1'b0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      cfg_error    <= 1'b0;
    end else begin
      done      <= 1'b0;
      trig_prev <= trig_in;
      if (s_valid) prev_ch0 <= ch0;
      if (state != IDLE && stop) stop_pending <= 1'b1;

      if (state == CAPTURE && s_valid && !space) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end

      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (start) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            cfg_error  <= 1'b0;
            if (n_new == '0) begin
              cfg_error <= 1'b1;
            end else begin
              mode_q       <= mode_new;
              cont_q       <= continuous;
              n_q          <= n_new;
              thr_q        <= threshold;
              beat_cnt     <= '0;
              trig_seen    <= 1'b0;
              stop_pending <= stop;
              busy         <= 1'b1;
              state        <= (mode_new == FREE) ? CAPTURE : ARMED;
            end
          end
        end

        ARMED: begin
          if (stop) begin
            stop_pending <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else if (fifo_wr) begin
            beat_cnt <= beat_cnt + 32'd1;
            state    <= is_last ? DRAIN : CAPTURE;
          end else if (trig_edge) begin
            trig_seen <= 1'b1;
          end
        end

        CAPTURE: begin
          if (fifo_wr) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (is_last) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (final_hs) begin
            if (cont_q && !stop_pending && !stop) begin
              beat_cnt  <= '0;
              trig_seen <= 1'b0;
              state     <= (mode_q == FREE) ? CAPTURE : ARMED;
            end else begin
              stop_pending <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (BEAT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (fifo_wr),
    .wr_data (fifo_din),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .empty   (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_dout[BEAT_W-1:0];
  assign m_tlast  = fifo_dout[BEAT_W];

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scenario bench for adc_capture_ctrl: expected beats queued while driving,
// observed handshakes collected on the falling edge and compared per scenario.
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_data;
  logic        s_valid, trig_in, start, stop, continuous, m_tready;
  logic [1:0]  mode;
  logic [31:0] packet_bytes;
  logic [15:0] threshold;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, busy, done, overflow, cfg_error;
  logic [15:0] drop_count;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -1;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  adc_capture_ctrl #(.DATA_W(16), .NUM_CH(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
    .trig_in(trig_in), .start(start), .stop(stop), .mode(mode),
    .continuous(continuous), .packet_bytes(packet_bytes), .threshold(threshold),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done), .overflow(overflow), .drop_count(drop_count),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn) begin
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        if (m_tlast) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] smp(input int c);
    return {16'(c + 4096), 16'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && !m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_data = '0; s_valid = 0; trig_in = 0; start = 0; stop = 0;
    mode = 0; continuous = 0; packet_bytes = 0; threshold = 0; m_tready = 1;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    vectors++;
    if ({m_tvalid, m_tlast, busy, done, overflow, cfg_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000000", {m_tvalid, m_tlast, busy, done, overflow, cfg_error});
    end
    vectors++;
    if (m_tdata !== 32'h0 || drop_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h exp=0/0", m_tdata, drop_count);
    end
  endtask

  task automatic test_free();
    logic [32:0] e, g;
    bit ok;
    int d0;
    d0 = done_cnt;
    mode = 0; continuous = 0; packet_bytes = 64;
    for (int c = 0; c < 24; c++) begin
      start = (c == 0); s_valid = 1; s_data = smp(c);
      if (c >= 1 && c <= 16) exp_q.push_back({c == 16, smp(c)});
      if (c == 1) begin
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL free_busy got=%b exp=1", busy); end
      end
      tick();
    end
    start = 0; s_valid = 0;
    wait_quiet(100, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL free_timeout got=busy exp=idle"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL free_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL free_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    vectors++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL free_done_cnt got=%0d exp=1", done_cnt - d0); end
    vectors++;
    if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL free_done_time got=%0d exp=%0d", done_cyc, last_cyc + 1); end
  endtask

  task automatic test_ext();
    logic [32:0] e, g;
    bit ok;
    mode = 1; continuous = 0; packet_bytes = 64; trig_in = 0;
    for (int c = 0; c <= 60; c++) begin
      start = (c == 0); s_valid = 1; s_data = smp(c); trig_in = (c >= 37);
      if (c >= 37 && c <= 52) exp_q.push_back({c == 52, smp(c)});
      if (c == 30) begin
        vectors++;
        if (busy !== 1'b1 || got_q.size() != 0) begin
          errors++; $display("FAIL ext_armed got=busy%b/beats%0d exp=busy1/beats0", busy, got_q.size());
        end
      end
      tick();
    end
    start = 0; s_valid = 0; trig_in = 0;
    wait_quiet(100, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL ext_timeout got=busy exp=idle"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ext_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL ext_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_level();
    logic [32:0] e, g;
    logic [31:0] d;
    bit ok;
    int d0;
    mode = 2; continuous = 0; packet_bytes = 64; threshold = 16'sd0;
    for (int i = 0; i <= 40; i++) begin
      d = {16'(i), 16'(-100 + 10 * i)};
      start = (i == 0); s_valid = 1; s_data = d;
      if (i >= 10 && i <= 25) exp_q.push_back({i == 25, d});
      tick();
    end
    start = 0; s_valid = 0;
    wait_quiet(100, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL level_timeout got=busy exp=idle"); end
    vectors++;
    if (got_q.size() == 0 || got_q[0][15:0] !== 16'h0000) begin
      errors++; $display("FAIL level_first got=%h exp=0000", got_q.size() ? got_q[0][15:0] : 16'hxxxx);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL level_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL level_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    // flat +5 never crosses 0 upward
    d0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      start = (i == 0); s_valid = 1; s_data = {16'(i), 16'sd5};
      tick();
    end
    start = 0; s_valid = 0;
    vectors++;
    if (busy !== 1'b1 || got_q.size() != 0) begin
      errors++; $display("FAIL level_flat got=busy%b/beats%0d exp=busy1/beats0", busy, got_q.size());
    end
    stop = 1; tick(); stop = 0; tick(); tick();
    vectors++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      errors++; $display("FAIL level_stop got=busy%b/done%0d exp=busy0/done0", busy, done_cnt - d0);
    end
    got_q.delete();
  endtask

  task automatic test_overflow();
    logic [32:0] e, g;
    bit ok;
    mode = 0; continuous = 0; packet_bytes = 64;
    for (int c = 0; c <= 40; c++) begin
      start = (c == 0); s_valid = 1; s_data = smp(c);
      m_tready = !(c >= 1 && c <= 20);
      if ((c >= 1 && c <= 4) || (c >= 21 && c <= 32)) exp_q.push_back({c == 32, smp(c)});
      tick();
    end
    start = 0; s_valid = 0; m_tready = 1;
    wait_quiet(100, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL ovf_timeout got=busy exp=idle"); end
    vectors++;
    if (overflow !== 1'b1 || drop_count !== 16'd16) begin
      errors++; $display("FAIL ovf_stats got=%b/%0d exp=1/16", overflow, drop_count);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL ovf_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_cfg_error();
    mode = 0; continuous = 0; packet_bytes = 3;
    start = 1; tick(); start = 0;
    vectors++;
    if (cfg_error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL cfg_reject got=err%b/busy%b exp=err1/busy0", cfg_error, busy);
    end
    vectors++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL cfg_clear got=%b/%0d exp=0/0", overflow, drop_count);
    end
    s_valid = 1; repeat (5) tick(); s_valid = 0; tick();
    vectors++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL cfg_idle got=busy%b/tvalid%b exp=0/0", busy, m_tvalid);
    end
  endtask

  task automatic test_start_stop();
    logic [32:0] e, g;
    bit ok;
    int d0;
    d0 = done_cnt;
    mode = 0; continuous = 1; packet_bytes = 16;
    for (int c = 0; c <= 30; c++) begin
      start = (c == 0); stop = (c == 0); s_valid = 1; s_data = smp(c + 1000);
      if (c >= 1 && c <= 4) exp_q.push_back({c == 4, smp(c + 1000)});
      if (c == 2) begin
        vectors++;
        if (cfg_error !== 1'b0) begin errors++; $display("FAIL ss_cfg_clear got=%b exp=0", cfg_error); end
      end
      tick();
    end
    start = 0; stop = 0; s_valid = 0;
    wait_quiet(50, ok);
    vectors++;
    if (!ok || done_cnt - d0 != 1) begin
      errors++; $display("FAIL ss_done got=ok%0d/done%0d exp=1/1", ok, done_cnt - d0);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ss_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL ss_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_continuous_stop();
    logic [32:0] e, g;
    logic [31:0] d;
    bit ok;
    int d0;
    d0 = done_cnt;
    mode = 0; continuous = 1; packet_bytes = 16;
    for (int c = 0; c <= 30; c++) begin
      start = (c == 0); stop = (c == 17);
      s_valid = (c >= 1 && c <= 4) || (c >= 15);
      d = (c <= 4) ? 32'(100 + c - 1) : 32'(200 + c - 15);
      s_data = d;
      if (c >= 1 && c <= 4) exp_q.push_back({c == 4, d});
      if (c >= 15 && c <= 18) exp_q.push_back({c == 18, d});
      if (c == 12) begin
        vectors++;
        if (busy !== 1'b1 || done_cnt != d0) begin
          errors++; $display("FAIL cont_rearm got=busy%b/done%0d exp=busy1/done0", busy, done_cnt - d0);
        end
      end
      tick();
    end
    start = 0; stop = 0; s_valid = 0;
    wait_quiet(50, ok);
    vectors++;
    if (!ok || busy !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL cont_done got=busy%b/done%0d exp=busy0/done1", busy, done_cnt - d0);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL cont_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL cont_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [32:0] e, g, held;
    bit ok, hold;
    hold = 1'b0; held = '0;
    mode = 0; continuous = 0; packet_bytes = 64;
    for (int c = 0; c <= 80; c++) begin
      start = (c == 0); s_valid = (c % 2 == 0) && (c > 0); s_data = smp(c + 2000);
      m_tready = (c % 3 != 0);
      if (s_valid && c <= 32) exp_q.push_back({c == 32, smp(c + 2000)});
      @(negedge clk);
      if (hold) begin
        vectors++;
        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, held}) begin
          errors++; $display("FAIL bp_stable got=%b/%h exp=1/%h", m_tvalid, {m_tlast, m_tdata}, held);
        end
      end
      hold = m_tvalid && !m_tready;
      held = {m_tlast, m_tdata};
      tick();
    end
    start = 0; s_valid = 0; m_tready = 1;
    wait_quiet(50, ok);
    vectors++;
    if (!ok || overflow !== 1'b0) begin errors++; $display("FAIL bp_end got=ok%0d/ovf%b exp=1/0", ok, overflow); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL bp_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    mode = 0; continuous = 0; packet_bytes = 64; m_tready = 0;
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0); s_valid = 1; s_data = smp(c + 3000);
      tick();
    end
    start = 0;
    vectors++;
    if (m_tvalid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre got=tvalid%b/busy%b exp=1/1", m_tvalid, busy);
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if ({m_tvalid, m_tlast, busy, done, overflow, cfg_error} !== 6'b0 || m_tdata !== 32'h0 || drop_count !== 16'h0) begin
      errors++; $display("FAIL rst_mid got=%b/%h/%h exp=000000/0/0",
                         {m_tvalid, m_tlast, busy, done, overflow, cfg_error}, m_tdata, drop_count);
    end
    tick(); tick();
    resetn = 1'b1; m_tready = 1;
    got_q.delete();
    for (int c = 0; c < 20; c++) begin
      s_data = smp(c + 4000);
      tick();
    end
    s_valid = 0; tick();
    vectors++;
    if (got_q.size() != 0 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_after got=beats%0d/busy%b exp=0/0", got_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_free();
    test_ext();
    test_level();
    test_overflow();
    test_cfg_error();
    test_start_stop();
    test_continuous_stop();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
